// File: rtl/queue_pkg.sv
// queue_pkg: widths and limits shared by the queue counter and the wait-time lookup
package queue_pkg;
  localparam int PW = 3;
  localparam int TW = 2;
  localparam int WW = 5;
  localparam int TSERVICE = 3;
  localparam int P_MAX = 7;
  localparam int T_MAX = 3;
endpackage

// File: rtl/wait_time_rom.sv
// wait_time_rom: combinational wait estimate floor(TSERVICE*(pCount+tCount-1)/tCount), zero for empty queue or no tellers
module wait_time_rom #(
  parameter int TSERVICE = queue_pkg::TSERVICE,
  parameter int PW = queue_pkg::PW,
  parameter int TW = queue_pkg::TW,
  parameter int WW = queue_pkg::WW
) (
  input  logic [PW-1:0] pCount,
  input  logic [TW-1:0] tCount,
  output logic [WW-1:0] wTime
);
  localparam int NW = WW + TW + 1;
  logic [NW-1:0] num;
  // ceil-style numerator divided by teller count; the zero cases mask the divide
  always_comb begin
    num = NW'(TSERVICE) * (NW'(pCount) + NW'(tCount) - NW'(1));
    wTime = (pCount == '0 || tCount == '0) ? '0 : WW'(num / NW'(tCount));
  end
endmodule

// File: rtl/wait_time_lut.sv
// wait_time_lut: registered wait-time lookup; define WAIT_TERR_EN to add the tErr illegal-teller flag
module wait_time_lut #(
  parameter int TSERVICE = queue_pkg::TSERVICE,
  parameter int PW = queue_pkg::PW,
  parameter int TW = queue_pkg::TW,
  parameter int WW = queue_pkg::WW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [PW-1:0] pCount,
  input  logic [TW-1:0] tCount,
`ifdef WAIT_TERR_EN
  output logic          tErr,
`endif
  output logic [WW-1:0] wTime
);
  logic [WW-1:0] romWait;
  wait_time_rom #(.TSERVICE(TSERVICE), .PW(PW), .TW(TW), .WW(WW)) rom (
    .pCount(pCount),
    .tCount(tCount),
    .wTime(romWait)
  );
  // one-cycle output register, reset wins
  always_ff @(posedge clk) wTime <= reset ? '0 : romWait;
`ifdef WAIT_TERR_EN
  // flag a non-empty queue with no open tellers
  always_ff @(posedge clk) tErr <= reset ? 1'b0 : (tCount == '0) && (pCount != '0);
`endif
endmodule

// File: tb/tb_wait_time_lut.sv
// tb_wait_time_lut: directed bench with a formula model checked every cycle plus literal table checks
module tb_wait_time_lut;
  logic clk = 0;
  logic reset = 1;
  logic [2:0] pCount = 0;
  logic [1:0] tCount = 1;
  logic [4:0] wTime;
  int checks = 0;
  int errors = 0;
  int expW = 0;
  bit valid = 0;
  int tbl[32];
`ifdef WAIT_TERR_EN
  logic tErr;
  int expE = 0;
`endif

  wait_time_lut dut (
    .clk(clk),
    .reset(reset),
    .pCount(pCount),
    .tCount(tCount),
`ifdef WAIT_TERR_EN
    .tErr(tErr),
`endif
    .wTime(wTime)
  );

  always #5 clk = ~clk;

  function automatic int model(int p, int t);
    if (p == 0 || t == 0) return 0;
    return (3 * (p + t - 1)) / t;
  endfunction

  // model captures the expected registered result on each rising edge
  always @(posedge clk) begin
    expW = reset ? 0 : model(int'(pCount), int'(tCount));
`ifdef WAIT_TERR_EN
    expE = (!reset && tCount == 0 && pCount != 0) ? 1 : 0;
`endif
    valid = 1;
  end

  // compare process away from the active edge
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (int'(wTime) != expW) begin
        errors++;
        $display("FAIL model_wTime t=%0t got %0d want %0d", $time, wTime, expW);
      end
`ifdef WAIT_TERR_EN
      checks++;
      if (int'(tErr) != expE) begin
        errors++;
        $display("FAIL model_tErr t=%0t got %0d want %0d", $time, tErr, expE);
      end
`endif
    end
  end

  task automatic apply(input int p, input int t, input bit r, input bit lit, input int want, input string name);
    @(negedge clk);
    pCount = 3'(p);
    tCount = 2'(t);
    reset = r;
    @(posedge clk);
    #1;
    if (lit) begin
      checks++;
      if (int'(wTime) != want) begin
        errors++;
        $display("FAIL %s got %0d want %0d", name, wTime, want);
      end
    end
  endtask

  initial begin
    tbl = '{0,0,0,0,0,0,0,0,
            0,3,6,9,12,15,18,21,
            0,3,4,6,7,9,10,12,
            0,3,4,5,6,7,8,9};
    apply(0, 1, 1, 1, 0, "reset_init");
    apply(0, 1, 1, 0, 0, "");
    for (int i = 0; i < 3; i++) apply(5, 1, 0, 1, 15, "pre_reset_5_1");
    apply(5, 1, 1, 1, 0, "reset_clears");
    apply(5, 1, 0, 1, 15, "after_reset_5_1");
    for (int t = 0; t < 4; t++)
      for (int p = 0; p < 8; p++) begin
        if (t == 2 && p == 3) apply(p, t, 1, 1, 0, "midstream_reset");
        else apply(p, t, 0, 1, tbl[t*8+p], $sformatf("sweep_p%0d_t%0d", p, t));
      end
    apply(7, 1, 0, 1, 21, "spot_7_1");
    apply(6, 2, 0, 1, 10, "spot_6_2");
    apply(7, 3, 0, 1, 9, "spot_7_3");
    for (int t = 1; t < 4; t++) apply(0, t, 0, 1, 0, "empty_queue");
    apply(4, 0, 0, 1, 0, "illegal_tellers");
`ifdef WAIT_TERR_EN
    checks++;
    if (tErr !== 1'b1) begin errors++; $display("FAIL terr_set got %0b want 1", tErr); end
`endif
    apply(4, 2, 0, 1, 7, "legal_after_illegal");
`ifdef WAIT_TERR_EN
    checks++;
    if (tErr !== 1'b0) begin errors++; $display("FAIL terr_clear got %0b want 0", tErr); end
`endif
    apply(1, 1, 0, 1, 3, "b2b_1");
    apply(2, 1, 0, 1, 6, "b2b_2");
    apply(3, 1, 0, 1, 9, "b2b_3");
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
